// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds VGA column/row counters from an incoming HSync/VSync pair
// and validates line/frame timing before reporting lock.
module vga_sync_decoder #(
    parameter int H_VISIBLE_AREA = 640,
    parameter int V_VISIBLE_AREA = 480,
    parameter int H_TOTAL        = 800,
    parameter int V_TOTAL        = 525,
    parameter int H_FRONT_PORCH  = 16,
    parameter int H_SYNC_PULSE   = 96,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_SYNC_PULSE   = 2,
    parameter int LOCK_LINES     = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_HSync,
    input  logic       i_VSync,
    output logic [9:0] o_Col,
    output logic [9:0] o_Row,
    output logic       o_Active,
    output logic       o_Line_Start,
    output logic       o_Frame_Start,
    output logic       o_Locked,
    output logic       o_Error
);
    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam logic [9:0]  H_LOAD = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [9:0]  V_LOAD = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] P_MAX  = 11'(2 * H_TOTAL);

    if (H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE > H_TOTAL ||
        V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE > V_TOTAL) begin : g_bad_timing
        $error("vga_sync_decoder: sync pulse does not fit inside the line or frame");
    end

    typedef enum logic [1:0] {SEARCH, MEASURE, WAIT_V, LOCKED} state_t;

    state_t        state_q, state_d;
    logic          hs_q, hs_prev_q, vs_q, vs_prev_q;
    logic          hs_fall_q, hs_rise_q, vs_fall_q, run_q;
    logic [9:0]    col_q, col_d, row_q, row_d, row_inc;
    logic [10:0]   period_q, period_d, width_q;
    logic [GW-1:0] good_q, good_d;
    logic          err_q, err_d, col_wrap, good_line, timeout;

    // Edge pulses are registered so the counters load one cycle after detection.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            hs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
            hs_fall_q <= 1'b0;
            hs_rise_q <= 1'b0;
            vs_fall_q <= 1'b0;
            run_q     <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            period_q  <= '0;
            width_q   <= '0;
            good_q    <= '0;
            err_q     <= 1'b0;
            state_q   <= SEARCH;
        end else begin
            hs_q      <= i_HSync;
            hs_prev_q <= hs_q;
            vs_q      <= i_VSync;
            vs_prev_q <= vs_q;
            hs_fall_q <= hs_prev_q & ~hs_q;
            hs_rise_q <= ~hs_prev_q & hs_q;
            vs_fall_q <= vs_prev_q & ~vs_q;
            run_q     <= run_q | hs_fall_q;
            col_q     <= col_d;
            row_q     <= row_d;
            period_q  <= period_d;
            width_q   <= hs_rise_q ? period_q : width_q;
            good_q    <= good_d;
            err_q     <= err_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        col_wrap  = run_q && col_q == H_LAST;
        col_d     = hs_fall_q ? H_LOAD : !run_q ? col_q : col_wrap ? 10'd0 : col_q + 10'd1;
        row_inc   = (col_wrap && !hs_fall_q) ? (row_q == V_LAST ? 10'd0 : row_q + 10'd1) : row_q;
        row_d     = vs_fall_q ? V_LOAD : row_inc;
        period_d  = hs_fall_q ? 11'd1 : period_q == P_MAX ? P_MAX : period_q + 11'd1;
        good_line = period_q == 11'(H_TOTAL) && width_q == 11'(H_SYNC_PULSE);
        timeout   = state_q != SEARCH && period_d == P_MAX && period_q != P_MAX;
    end

    // The VSync check uses the row the counter would hold without the VSync load.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = 1'b0;
        case (state_q)
            SEARCH: begin
                if (hs_fall_q) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (hs_fall_q) begin
                    good_d  = good_line ? good_q + GW'(1) : '0;
                    state_d = (good_line && good_q == GW'(LOCK_LINES - 1)) ? WAIT_V : MEASURE;
                end
            end
            WAIT_V: begin
                if (hs_fall_q && !good_line) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end else if (vs_fall_q) begin
                    state_d = LOCKED;
                end
            end
            default: begin
                if ((hs_fall_q && !good_line) || (vs_fall_q && row_inc != V_LOAD)) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end
            end
        endcase
        if (timeout) begin
            state_d = SEARCH;
            err_d   = 1'b1;
        end
    end

    always_comb begin
        o_Col         = col_q;
        o_Row         = row_q;
        o_Locked      = state_q == LOCKED;
        o_Error       = err_q;
        o_Active      = o_Locked && col_q < 10'(H_VISIBLE_AREA) && row_q < 10'(V_VISIBLE_AREA);
        o_Line_Start  = o_Locked && col_q == 10'd0;
        o_Frame_Start = o_Line_Start && row_q == 10'd0;
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives a reduced-size VGA sync generator into the decoder and
// compares the rebuilt counters against the generator position two clocks earlier.
module tb_vga_sync_decoder;
    localparam int HV = 16, HFP = 4, HS = 6, HT = 32;
    localparam int VV = 12, VFP = 2, VS = 2, VT = 20, LK = 4;
    localparam int HL = HV + HFP, VL = VV + VFP, FRAME = HT * VT;

    logic       i_Clk = 1'b0, i_Rst = 1'b1, i_HSync = 1'b1, i_VSync = 1'b1;
    logic [9:0] o_Col, o_Row;
    logic       o_Active, o_Line_Start, o_Frame_Start, o_Locked, o_Error;

    typedef struct {int c; int r;} samp_t;
    samp_t sb[$];

    int n_run = 0, n_fail = 0, ncyc = 0, gcol = 0, grow = 0;
    int exp_c = -1, exp_r = -1, hs_w = HS, last_fs = -1, nfs = 0;
    bit track = 1'b0, stretch = 1'b0, hs_hold = 1'b0, vs_inj = 1'b0;

    vga_sync_decoder #(
        .H_VISIBLE_AREA(HV), .V_VISIBLE_AREA(VV), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HS), .V_FRONT_PORCH(VFP),
        .V_SYNC_PULSE(VS), .LOCK_LINES(LK)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_HSync(i_HSync), .i_VSync(i_VSync),
        .o_Col(o_Col), .o_Row(o_Row), .o_Active(o_Active), .o_Line_Start(o_Line_Start),
        .o_Frame_Start(o_Frame_Start), .o_Locked(o_Locked), .o_Error(o_Error)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: drive the generator sample, then compare against the sample from two edges back.
    task automatic tick(input bit rst);
        samp_t s;
        i_Rst   = rst;
        i_HSync = hs_hold || !(gcol >= HL && gcol < HL + hs_w);
        i_VSync = !((grow >= VL && grow < VL + VS) || (vs_inj && grow == 6));
        sb.push_back('{gcol, grow});
        @(posedge i_Clk);
        #1;
        ncyc++;
        if (sb.size() == 3) begin
            s     = sb.pop_front();
            exp_c = s.c;
            exp_r = s.r;
        end
        if (track) begin
            check("pos", 32'({o_Row, o_Col}), 32'({10'(exp_r), 10'(exp_c)}));
            check("flags", 32'({o_Active, o_Line_Start, o_Frame_Start, o_Locked, o_Error}),
                  32'({exp_c < HV && exp_r < VV, exp_c == 0, exp_c == 0 && exp_r == 0, 1'b1, 1'b0}));
            if (o_Frame_Start) begin
                if (last_fs >= 0) check("fs_period", ncyc - last_fs, FRAME);
                last_fs = ncyc;
                nfs++;
            end
        end
        if (stretch && gcol == HT - 1) stretch = 1'b0;
        else begin
            gcol = (gcol + 1) % HT;
            if (gcol == 0) grow = (grow + 1) % VT;
        end
    endtask

    task automatic run_to(input int r, input int c);
        int n;
        n = 0;
        while (!(grow == r && gcol == c) && n < 2 * FRAME) begin
            tick(1'b0);
            n++;
        end
    endtask

    task automatic track_run(input int cycles);
        track   = 1'b1;
        last_fs = -1;
        nfs     = 0;
        repeat (cycles) tick(1'b0);
        track = 1'b0;
    endtask

    task automatic wait_err(input string tag, input int pos);
        int n;
        n = 0;
        while (o_Error !== 1'b1 && n < 2 * FRAME) begin
            tick(1'b0);
            n++;
        end
        check({tag, "_err_pos"}, o_Error === 1'b1 ? exp_r * HT + exp_c : -1, pos);
        check({tag, "_unlocked"}, 32'(o_Locked), 0);
    endtask

    task automatic wait_lock(input string tag);
        int n, errs;
        n    = 0;
        errs = 0;
        while (o_Locked !== 1'b1 && n < 2 * FRAME) begin
            tick(1'b0);
            n++;
            errs += int'(o_Error);
        end
        check({tag, "_lock_pos"}, o_Locked === 1'b1 ? exp_r * HT + exp_c : -1, VL * HT);
        check({tag, "_lock_rowcol"}, 32'({o_Row, o_Col}), 32'({10'(VL), 10'd0}));
        check({tag, "_lock_errs"}, errs, 0);
        check({tag, "_lock_in_frame"}, 32'(n <= FRAME), 1);
    endtask

    task automatic rst_mid();
        int n;
        n = 0;
        tick(1'b1);
        check("rst_mid_outputs",
              32'({o_Col, o_Row, o_Active, o_Line_Start, o_Frame_Start, o_Locked, o_Error}), 0);
        while (!(exp_r == 5 && exp_c == HL) && n < HT) begin
            check("rst_col_hold", 32'(o_Col), 0);
            tick(1'b0);
            n++;
        end
        check("rst_col_load", 32'(o_Col), HL);
    endtask

    initial begin
        tick(1'b1);
        tick(1'b1);
        check("rst_outputs",
              32'({o_Col, o_Row, o_Active, o_Line_Start, o_Frame_Start, o_Locked, o_Error}), 0);
        wait_lock("clean");
        check("clean_lock_cycle", ncyc, VL * HT + 3);
        track_run(2 * FRAME + 10);
        check("clean_fs_count", nfs, 2);

        run_to(5, 0);
        stretch = 1'b1;
        wait_err("stretch", 6 * HT + HL);
        wait_lock("stretch");
        track_run(FRAME);

        run_to(5, 0);
        hs_w = HS - 1;
        run_to(6, 0);
        hs_w = HS;
        wait_err("narrow", 6 * HT + HL);
        wait_lock("narrow");
        track_run(FRAME);

        run_to(5, 30);
        hs_hold = 1'b1;
        wait_err("hold", 5 * HT + HL + 2 * HT - 1);
        run_to(8, 0);
        hs_hold = 1'b0;
        wait_lock("hold");
        track_run(FRAME);

        run_to(5, 0);
        vs_inj = 1'b1;
        wait_err("vinj", 6 * HT);
        check("vinj_rowcol", 32'({o_Row, o_Col}), 32'({10'(VL), 10'd0}));
        vs_inj = 1'b0;
        wait_lock("vinj");
        track_run(FRAME);

        run_to(5, 2);
        rst_mid();
        wait_lock("rst");
        track_run(2 * FRAME + 10);
        check("rst_fs_count", nfs, 2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
